// File: rtl/fd_pkg.sv
// Shared types, default parameters and address helpers for the FAST scan controller.
package fd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    EVAL
  } fdState_t;

  localparam int FD_IMG_W      = 177;
  localparam int FD_IMG_H      = 120;
  localparam int FD_BORDER     = 3;
  localparam int FD_ADJ_N      = 16;
  localparam int FD_PIPE_LAT   = 2;
  localparam int FD_ADDR_W     = 15;
  localparam int FD_CONTINUOUS = 0;

  // Linear address of the first interior pixel.
  function automatic int firstAddr(input int imgW, input int border);
    return border * imgW + border;
  endfunction

  // Linear address of the last interior pixel.
  function automatic int lastAddr(input int imgW, input int imgH, input int border);
    return (imgH - 1 - border) * imgW + (imgW - 1 - border);
  endfunction

endpackage

// File: rtl/fd_adj_delay.sv
// Delay line aligning circle-point indices with the compare stage's register-file reads.
module fd_adj_delay #(
  parameter int LAT = 2,
  parameter int W   = 6
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (LAT == 0) begin : gWire
    assign dout = din;
  end else begin : gPipe
    logic [W-1:0] stage [LAT];

    // Shift one stage per enabled cycle; clear flushes every stage.
    always_ff @(posedge clock) begin
      if (clear) begin
        for (int unsigned i = 0; i < LAT; i++) stage[i] <= '0;
      end else if (enable) begin
        stage[0] <= din;
        for (int unsigned i = 1; i < LAT; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[LAT-1];
  end

endmodule

// File: rtl/fd_scan_controller.sv
// Raster scan sequencer: issues circle-point fetches per interior pixel and strobes evaluation.
module fd_scan_controller
  import fd_pkg::*;
#(
  parameter int IMG_W      = FD_IMG_W,
  parameter int IMG_H      = FD_IMG_H,
  parameter int BORDER     = FD_BORDER,
  parameter int ADJ_N      = FD_ADJ_N,
  parameter int PIPE_LAT   = FD_PIPE_LAT,
  parameter int ADDR_W     = FD_ADDR_W,
  parameter int CONTINUOUS = FD_CONTINUOUS
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              start,
  input  logic              hold,
  output logic [ADDR_W-1:0] refAddr,
  output logic [4:0]        adjNumber,
  output logic              adj_valid,
  output logic [4:0]        regAddr,
  output logic              reg_valid,
  output logic              readen,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [ADDR_W-1:0] FIRST     = ADDR_W'(firstAddr(IMG_W, BORDER));
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(2 * BORDER + 1);
  localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(BORDER);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1 - BORDER);
  localparam logic [ROW_W-1:0]  ROW_FIRST = ROW_W'(BORDER);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1 - BORDER);
  localparam logic [4:0]        K_LAST    = 5'(ADJ_N - 1);
  localparam logic [2:0]        D_LAST    = 3'((PIPE_LAT == 0) ? 0 : PIPE_LAT - 1);

  if (ADJ_N < 1 || ADJ_N > 32) begin : gBadAdjN
    $error("fd_scan_controller: ADJ_N must be 1..32");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 4) begin : gBadPipeLat
    $error("fd_scan_controller: PIPE_LAT must be 0..4");
  end
  if ((longint'(IMG_W) * longint'(IMG_H)) > (longint'(1) << ADDR_W)) begin : gBadAddrW
    $error("fd_scan_controller: ADDR_W too narrow for IMG_W*IMG_H");
  end

  fdState_t         state;
  logic [4:0]       k;
  logic [2:0]       dCnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             adjValidQ;
  logic             readenQ;
  logic             doneQ;
  logic             busyQ;
  logic             lastPixel;
  logic [5:0]       pipeOut;

  assign lastPixel = (row == ROW_LAST) && (col == COL_LAST);

  // k doubles as the issued index: it is held at 0 outside ISSUE, so adjNumber needs no masking.
  // Scan FSM; all state freezes while hold is high.
  always_ff @(posedge clock) begin
    if (!nReset) begin
      state     <= IDLE;
      k         <= '0;
      dCnt      <= '0;
      col       <= COL_FIRST;
      row       <= ROW_FIRST;
      refAddr   <= FIRST;
      adjValidQ <= 1'b0;
      readenQ   <= 1'b0;
      doneQ     <= 1'b0;
      busyQ     <= 1'b0;
    end else if (!hold) begin
      readenQ <= 1'b0;
      doneQ   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            k         <= '0;
            col       <= COL_FIRST;
            row       <= ROW_FIRST;
            refAddr   <= FIRST;
            adjValidQ <= 1'b1;
            busyQ     <= 1'b1;
          end
        end
        ISSUE: begin
          if (k == K_LAST) begin
            k         <= '0;
            adjValidQ <= 1'b0;
            if (PIPE_LAT == 0) begin
              state   <= EVAL;
              readenQ <= 1'b1;
            end else begin
              state <= DRAIN;
              dCnt  <= '0;
            end
          end else begin
            k <= k + 5'd1;
          end
        end
        DRAIN: begin
          if (dCnt == D_LAST) begin
            state   <= EVAL;
            readenQ <= 1'b1;
            dCnt    <= '0;
          end else begin
            dCnt <= dCnt + 3'd1;
          end
        end
        EVAL: begin
          if (lastPixel) begin
            doneQ <= 1'b1;
            if (CONTINUOUS != 0) begin
              state     <= ISSUE;
              adjValidQ <= 1'b1;
              refAddr   <= FIRST;
              col       <= COL_FIRST;
              row       <= ROW_FIRST;
            end else begin
              state <= IDLE;
              busyQ <= 1'b0;
            end
          end else begin
            state     <= ISSUE;
            adjValidQ <= 1'b1;
            if (col == COL_LAST) begin
              col     <= COL_FIRST;
              row     <= row + ROW_W'(1);
              refAddr <= refAddr + ROW_STEP;
            end else begin
              col     <= col + COL_W'(1);
              refAddr <= refAddr + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fd_adj_delay #(
    .LAT (PIPE_LAT),
    .W   (6)
  ) uDelay (
    .clock  (clock),
    .clear  (!nReset),
    .enable (!hold),
    .din    ({adjValidQ, k}),
    .dout   (pipeOut)
  );

  assign adjNumber = k;
  assign adj_valid = adjValidQ & ~hold;
  assign regAddr   = pipeOut[4:0];
  assign reg_valid = pipeOut[5] & ~hold;
  assign readen    = readenQ & ~hold;
  assign done      = doneQ & ~hold;
  assign busy      = busyQ;

endmodule

// File: tb/tb_fd_scan_controller.sv
// Directed bench: default-size timing, row wrap, hold, reset, and small-frame full scans.
module tb_fd_scan_controller;

  logic clock   = 1'b0;
  logic nReset  = 1'b0;
  logic start0  = 1'b0;
  logic start1  = 1'b0;
  logic start2  = 1'b0;
  logic hold0   = 1'b0;
  logic holdOff = 1'b0;

  logic [14:0] refAddr0;
  logic [4:0]  adjNumber0, regAddr0;
  logic        adj_valid0, reg_valid0, readen0, busy0, done0;

  logic [6:0]  refAddr1;
  logic [4:0]  adjNumber1, regAddr1;
  logic        adj_valid1, reg_valid1, readen1, busy1, done1;

  logic [6:0]  refAddr2;
  logic [4:0]  adjNumber2, regAddr2;
  logic        adj_valid2, reg_valid2, readen2, busy2, done2;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clock = ~clock;

  // Default geometry, single-frame.
  fd_scan_controller uDut0 (
    .clock(clock), .nReset(nReset), .start(start0), .hold(hold0),
    .refAddr(refAddr0), .adjNumber(adjNumber0), .adj_valid(adj_valid0),
    .regAddr(regAddr0), .reg_valid(reg_valid0), .readen(readen0),
    .busy(busy0), .done(done0)
  );

  // 10x9 frame, 4x3 interior, P = 4+1+1 = 6.
  fd_scan_controller #(
    .IMG_W(10), .IMG_H(9), .BORDER(3), .ADJ_N(4), .PIPE_LAT(1),
    .ADDR_W(7), .CONTINUOUS(0)
  ) uDut1 (
    .clock(clock), .nReset(nReset), .start(start1), .hold(holdOff),
    .refAddr(refAddr1), .adjNumber(adjNumber1), .adj_valid(adj_valid1),
    .regAddr(regAddr1), .reg_valid(reg_valid1), .readen(readen1),
    .busy(busy1), .done(done1)
  );

  // 10x9 frame, zero latency, continuous, P = 13.
  fd_scan_controller #(
    .IMG_W(10), .IMG_H(9), .BORDER(3), .ADJ_N(12), .PIPE_LAT(0),
    .ADDR_W(7), .CONTINUOUS(1)
  ) uDut2 (
    .clock(clock), .nReset(nReset), .start(start2), .hold(holdOff),
    .refAddr(refAddr2), .adjNumber(adjNumber2), .adj_valid(adj_valid2),
    .regAddr(regAddr2), .reg_valid(reg_valid2), .readen(readen2),
    .busy(busy2), .done(done2)
  );

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  int n, badCol, expReg, readenAt, lastRdC, doneC, doneCount, colIdx;
  logic [6:0] exp1 [12] = '{7'd33, 7'd34, 7'd35, 7'd36, 7'd43, 7'd44,
                            7'd45, 7'd46, 7'd53, 7'd54, 7'd55, 7'd56};

  initial begin
    @(negedge clock);
    tick;
    tick;
    checkVal("reset refAddr", 32'(refAddr0), 534);
    checkVal("reset adj_valid", 32'(adj_valid0), 0);
    checkVal("reset adjNumber", 32'(adjNumber0), 0);
    checkVal("reset reg_valid", 32'(reg_valid0), 0);
    checkVal("reset regAddr", 32'(regAddr0), 0);
    checkVal("reset readen", 32'(readen0), 0);
    checkVal("reset busy", 32'(busy0), 0);
    checkVal("reset done", 32'(done0), 0);
    nReset = 1'b1;
    tick;
    checkVal("idle busy", 32'(busy0), 0);

    // First pixel: cycle 1 is the first ISSUE cycle.
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      checkVal("p0 busy", 32'(busy0), 1);
      checkVal("p0 refAddr", 32'(refAddr0), 534);
      checkVal("p0 adj_valid", 32'(adj_valid0), (c <= 16) ? 1 : 0);
      checkVal("p0 adjNumber", 32'(adjNumber0), (c <= 16) ? c - 1 : 0);
      checkVal("p0 reg_valid", 32'(reg_valid0), (c >= 3 && c <= 18) ? 1 : 0);
      checkVal("p0 regAddr", 32'(regAddr0), (c >= 3 && c <= 18) ? c - 3 : 0);
      checkVal("p0 readen", 32'(readen0), (c == 19) ? 1 : 0);
      tick;
    end

    // Second pixel with a 5-cycle hold at k=7.
    expReg = 0;
    readenAt = -1;
    for (int c = 20; c <= 44; c++) begin
      if (c == 27) hold0 = 1'b1;
      if (c == 32) hold0 = 1'b0;
      #1;
      if (c == 20) checkVal("p1 refAddr", 32'(refAddr0), 535);
      if (reg_valid0) begin
        checkVal("hold regAddr seq", 32'(regAddr0), 32'(expReg));
        expReg++;
      end
      if (readen0) readenAt = c;
      if (c >= 27 && c <= 31) begin
        checkVal("hold adj_valid", 32'(adj_valid0), 0);
        checkVal("hold adjNumber", 32'(adjNumber0), 7);
      end
      if (c == 32) begin
        checkVal("post-hold adj_valid", 32'(adj_valid0), 1);
        checkVal("post-hold adjNumber", 32'(adjNumber0), 7);
      end
      if (c == 44) checkVal("p2 refAddr", 32'(refAddr0), 536);
      tick;
    end
    checkVal("hold reg_valid count", 32'(expReg), 16);
    checkVal("hold readen cycle", 32'(readenAt), 43);

    // Now at cycle 45 (pixel 536, k=1): start while busy must be ignored.
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    checkVal("busy start adjNumber", 32'(adjNumber0), 2);
    checkVal("busy start refAddr", 32'(refAddr0), 536);
    for (int i = 0; i < 8; i++) tick;
    checkVal("pre-reset adjNumber", 32'(adjNumber0), 10);
    nReset = 1'b0;
    tick;
    checkVal("midreset refAddr", 32'(refAddr0), 534);
    checkVal("midreset adj_valid", 32'(adj_valid0), 0);
    checkVal("midreset adjNumber", 32'(adjNumber0), 0);
    checkVal("midreset reg_valid", 32'(reg_valid0), 0);
    checkVal("midreset regAddr", 32'(regAddr0), 0);
    checkVal("midreset readen", 32'(readen0), 0);
    checkVal("midreset busy", 32'(busy0), 0);
    nReset = 1'b1;
    tick;
    tick;
    checkVal("post-reset idle adj_valid", 32'(adj_valid0), 0);
    checkVal("post-reset idle busy", 32'(busy0), 0);

    // Row wrap: pixel index 170 is 704, index 171 is 711.
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    n = 0;
    badCol = 0;
    for (int c = 0; c < 4000 && n < 172; c++) begin
      if (readen0) begin
        if (n == 0)   checkVal("wrap first", 32'(refAddr0), 534);
        if (n == 170) checkVal("wrap row end", 32'(refAddr0), 704);
        if (n == 171) checkVal("wrap next row", 32'(refAddr0), 711);
        colIdx = int'(refAddr0) % 177;
        if (colIdx < 3 || colIdx > 173) badCol++;
        n++;
      end
      tick;
    end
    checkVal("wrap readen count", 32'(n), 172);
    checkVal("wrap border columns", 32'(badCol), 0);

    // Small full frame, single shot.
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    n = 0;
    lastRdC = -1;
    doneC = -1;
    doneCount = 0;
    for (int c = 1; c <= 150; c++) begin
      if (c == 1) checkVal("u1 start busy", 32'(busy1), 1);
      if (c == 3) checkVal("u1 regAddr delay", 32'(regAddr1), 1);
      if (readen1) begin
        if (n < 12) checkVal("u1 readen addr", 32'(refAddr1), 32'(exp1[n]));
        n++;
        lastRdC = c;
      end
      if (done1) begin
        doneCount++;
        doneC = c;
      end
      tick;
    end
    checkVal("u1 readen count", 32'(n), 12);
    checkVal("u1 last readen cycle", 32'(lastRdC), 72);
    checkVal("u1 done count", 32'(doneCount), 1);
    checkVal("u1 done cycle", 32'(doneC), 73);
    checkVal("u1 idle busy", 32'(busy1), 0);
    checkVal("u1 idle adj_valid", 32'(adj_valid1), 0);

    // Zero-latency continuous frame.
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    n = 0;
    for (int c = 1; c <= 14; c++) begin
      checkVal("u2 regAddr same cycle", 32'(regAddr2), 32'(adjNumber2));
      checkVal("u2 reg_valid same cycle", 32'(reg_valid2), 32'(adj_valid2));
      checkVal("u2 adjNumber", 32'(adjNumber2), (c <= 12) ? c - 1 : 0);
      checkVal("u2 readen", 32'(readen2), (c == 13) ? 1 : 0);
      if (c == 14) checkVal("u2 next refAddr", 32'(refAddr2), 34);
      if (readen2) n++;
      tick;
    end
    doneC = -1;
    for (int c = 15; c <= 200 && doneC < 0; c++) begin
      if (readen2) n++;
      if (done2) begin
        doneC = c;
        checkVal("u2 done refAddr", 32'(refAddr2), 33);
        checkVal("u2 done adj_valid", 32'(adj_valid2), 1);
        checkVal("u2 done adjNumber", 32'(adjNumber2), 0);
        checkVal("u2 done busy", 32'(busy2), 1);
      end
      tick;
    end
    checkVal("u2 readen count", 32'(n), 12);
    checkVal("u2 done cycle", 32'(doneC), 157);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
